// File: rtl/if_id_stage_reg_if.sv
// if_id_stage_reg_if: IF->ID pipeline register bus.
// master (pipeline control / fetch side) drives stall, flush, cnt_clr and the *_f payload.
// slave (the register) returns the *_d payload, victim capture and performance counters.
interface if_id_stage_reg_if #(
  parameter int PC_W = 32,
  parameter int INSTR_W = 32,
  parameter int EXC_W = 5,
  parameter int CNT_W = 16
);
  logic stall, flush, cnt_clr;
  logic valid_f, bd_f;
  logic [PC_W-1:0] pc_f;
  logic [INSTR_W-1:0] instr_f;
  logic [EXC_W-1:0] exc_f;
  logic valid_d, bd_d;
  logic [PC_W-1:0] pc_d, pcplus4_d, pcplus8_d;
  logic [INSTR_W-1:0] instr_d;
  logic [EXC_W-1:0] exc_d;
  logic victim_valid, victim_bd;
  logic [PC_W-1:0] victim_pc;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    output stall, flush, cnt_clr, valid_f, pc_f, instr_f, bd_f, exc_f,
    input valid_d, pc_d, pcplus4_d, pcplus8_d, instr_d, bd_d, exc_d,
    input victim_valid, victim_pc, victim_bd, stall_cnt, flush_cnt
  );
  modport slave (
    input stall, flush, cnt_clr, valid_f, pc_f, instr_f, bd_f, exc_f,
    output valid_d, pc_d, pcplus4_d, pcplus8_d, instr_d, bd_d, exc_d,
    output victim_valid, victim_pc, victim_bd, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/if_id_stage_reg.sv
// if_id_stage_reg: IF->ID pipeline register with stall/flush, victim PC capture and perf counters.
// Ports: clk, reset (async, active-high), bus (slave side of if_id_stage_reg_if).
module if_id_stage_reg #(
  parameter int PC_W = 32,
  parameter int INSTR_W = 32,
  parameter int EXC_W = 5,
  parameter logic [PC_W-1:0] RESET_PC = 'h0000_3000,
  parameter logic [INSTR_W-1:0] NOP = '0,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  if_id_stage_reg_if.slave bus
);
  logic valid, bd, victim_valid, victim_bd;
  logic [PC_W-1:0] pc, victim_pc;
  logic [INSTR_W-1:0] instr;
  logic [EXC_W-1:0] exc;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      pc <= RESET_PC;
      instr <= NOP;
      bd <= 1'b0;
      exc <= '0;
      victim_valid <= 1'b0;
      victim_pc <= '0;
      victim_bd <= 1'b0;
    end else if (bus.flush) begin
      // pc_d is kept so a later flush of an empty slot still shows the last fetch address
      valid <= 1'b0;
      instr <= NOP;
      bd <= 1'b0;
      exc <= '0;
      victim_valid <= valid;
      if (valid) begin
        victim_pc <= pc;
        victim_bd <= bd;
      end
    end else if (bus.stall) begin
      victim_valid <= 1'b0;
    end else begin
      valid <= bus.valid_f;
      pc <= bus.pc_f;
      instr <= bus.valid_f ? bus.instr_f : NOP;
      bd <= bus.bd_f & bus.valid_f;
      exc <= bus.exc_f;
      victim_valid <= 1'b0;
    end
  end
  // Counters saturate at all-ones; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (bus.cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.flush && valid && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
      if (!bus.flush && bus.stall && valid && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
  assign bus.valid_d = valid;
  assign bus.pc_d = pc;
  assign bus.pcplus4_d = pc + PC_W'(4);
  assign bus.pcplus8_d = pc + PC_W'(8);
  assign bus.instr_d = instr;
  assign bus.bd_d = bd;
  assign bus.exc_d = exc;
  assign bus.victim_valid = victim_valid;
  assign bus.victim_pc = victim_pc;
  assign bus.victim_bd = victim_bd;
  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;
endmodule

// File: doc/if_id_stage_reg.md
Name: if_id_stage_reg

Overview:
- Parametrised IF→ID pipeline register for the 5-stage MIPS core.
- Carries fetch payload into decode: PC, instruction, delay-slot flag, fetch exception code, and an explicit valid bit.
- Supports stall (hold), flush (interrupt or exception kill) and bubble propagation.
- Captures the PC of a killed instruction for EPC, and keeps saturating stall and flush performance counters.

Parameters:
- PC_W, 32, PC width.
- INSTR_W, 32, instruction width.
- EXC_W, 5, fetch exception code width (0 = no exception).
- RESET_PC, 32'h0000_3000, PC presented in ID after reset.
- NOP, 0, instruction word injected on bubble or flush.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold ID contents.
- flush  in  1  kill the ID contents (interrupt or exception).
- cnt_clr  in  1  synchronous clear of both counters.
- valid_f  in  1  IF slot holds a real instruction.
- pc_f  in  PC_W  IF PC.
- instr_f  in  INSTR_W  IF instruction.
- bd_f  in  1  IF instruction sits in a branch delay slot.
- exc_f  in  EXC_W  IF exception code.
- valid_d  out  1  ID slot valid.
- pc_d  out  PC_W  ID PC.
- pcplus4_d  out  PC_W  pc_d+4.
- pcplus8_d  out  PC_W  pc_d+8.
- instr_d  out  INSTR_W  ID instruction.
- bd_d  out  1  ID delay-slot flag.
- exc_d  out  EXC_W  ID exception code.
- victim_valid  out  1  one-cycle pulse: a valid instruction was flushed.
- victim_pc  out  PC_W  PC of the last flushed valid instruction.
- victim_bd  out  1  delay-slot flag of the last flushed valid instruction.
- stall_cnt  out  CNT_W  cycles spent stalled with a valid instruction in ID.
- flush_cnt  out  CNT_W  number of valid instructions flushed.

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately, including mid-stall or mid-flush):
  - valid_d=0, instr_d=NOP, pc_d=RESET_PC, bd_d=0, exc_d=0.
  - victim_valid=0, victim_pc=0, victim_bd=0, stall_cnt=0, flush_cnt=0.
- Each rising edge, priority is flush > stall > load.
- Flush:
  - valid_d←0, instr_d←NOP, bd_d←0, exc_d←0; pc_d holds.
  - If valid_d was 1: victim_pc←pc_d, victim_bd←bd_d, victim_valid←1, flush_cnt increments.
  - Otherwise victim_valid←0 and victim_pc/victim_bd hold.
- Stall without flush:
  - All payload registers and valid_d hold; victim_valid←0.
  - If valid_d=1, stall_cnt increments.
- Load (no flush, no stall):
  - valid_d←valid_f, pc_d←pc_f, exc_d←exc_f.
  - instr_d←instr_f when valid_f=1, else NOP.
  - bd_d←bd_f & valid_f.
  - victim_valid←0.
- Latency: one cycle from IF inputs to ID outputs. No combinational path from any input to any output.
- pcplus4_d and pcplus8_d are combinational from pc_d, modulo 2^PC_W (wrap-around, no carry out).
- Counters:
  - Saturate at all-ones and never wrap.
  - cnt_clr zeroes both counters and takes priority over an increment in the same cycle.
  - cnt_clr does not affect pipeline state.
- victim_valid is registered and high for exactly one cycle per flushed valid instruction. Back-to-back flushes pulse only when the slot was valid each time (normally only the first).
- exc_d≠0 with valid_d=1 is a legal state that decode must act on; this block does not interpret exception codes.

Test Plan:
- Reset asserted mid-cycle while valid_d=1 and stall=1 → outputs clear immediately without waiting for a clock edge: pc_d=32'h3000, pcplus4_d=32'h3004, pcplus8_d=32'h3008, instr_d=0, valid_d=0, counters=0.
- Load pc_f=32'h3010, instr_f=32'h2408_0005, valid_f=1, bd_f=1 → next cycle pc_d=32'h3010, pcplus8_d=32'h3018, instr_d=32'h2408_0005, bd_d=1, valid_d=1. Then valid_f=0 → instr_d=0, bd_d=0, valid_d=0.
- With valid_d=1, hold stall=1 for 3 cycles while the IF inputs change → ID outputs unchanged and stall_cnt=3. Repeat with valid_d=0 → stall_cnt does not increment.
- With valid_d=1, pc_d=32'h3020, bd_d=1, assert flush and stall together → valid_d=0, instr_d=0, pc_d=32'h3020, victim_pc=32'h3020, victim_bd=1, victim_valid high for exactly 1 cycle, flush_cnt=1. A second consecutive flush → no pulse and flush_cnt stays 1.
- Set CNT_W=2 and stall with a valid instruction for 6 cycles → stall_cnt=3 (saturated). Then assert cnt_clr together with stall → stall_cnt=0.
- pc_f=32'hFFFF_FFFC loaded → pcplus4_d=32'h0000_0000, pcplus8_d=32'h0000_0004.
